// File: rtl/memoria_pkg.sv
// memoria_pkg
//    Shared types and default sizing for the parametrised data memory
//    (memoria_dados_param) of the nRISC datapath.
//
//    memoria_estado_t : controller state (zero-fill sweep vs. normal service)
//    MEM_DATA_W       : default word width in bits
//    MEM_ADDR_W       : default address width in bits
//    MEM_DEPTH        : default number of implemented words
//
//    Optional build macro used by the top level: MEMORIA_BYPASS_EN.

package memoria_pkg;

   typedef enum logic {
      MEM_INIT = 1'b0,
      MEM_RUN  = 1'b1
   } memoria_estado_t;

   localparam int MEM_DATA_W = 8;
   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DEPTH  = 256;

   // Index width needed to address DEPTH words; never below one bit so a
   // single-word memory still has a legal index.
   function automatic int mem_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/memoria_array.sv
// memoria_array
//    Plain word storage for memoria_dados_param: one synchronous write port
//    and one registered, read-first read port. The storage itself has no
//    reset; only the read register is cleared so the output is defined
//    straight after reset.
//
//    Ports:
//       clock   in   rising-edge clock
//       reset   in   synchronous active-high, clears the read register only
//       we      in   write enable
//       waddr   in   write address (caller guarantees waddr < DEPTH)
//       wdata   in   write data
//       re      in   read enable; rdata holds when low
//       raddr   in   read address (caller guarantees raddr < DEPTH)
//       rdata   out  registered read data (old contents on a same-edge write)

module memoria_array
   import memoria_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int IDX_W = mem_idx_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  widx;
   logic [IDX_W-1:0]  ridx;

   // Only the low bits select a word; the caller has already rejected any
   // address at or above DEPTH.
   assign widx = IDX_W'(waddr);
   assign ridx = IDX_W'(raddr);

   always_ff @(posedge clock) begin
      if (we) begin
         mem[widx] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[ridx];
      end
   end

endmodule

// File: rtl/memoria_dados_param.sv
// memoria_dados_param
//    Parametrised single-port data memory sitting between the ALU address
//    path and the register-file write-back mux. After reset a hardware sweep
//    writes zero to every word (DEPTH cycles); only then is pronto raised and
//    requests accepted. Reads are registered with a one-cycle lidoValido
//    strobe; addresses at or above DEPTH are rejected and flagged on erroEnd.
//
//    Build macro MEMORIA_BYPASS_EN:
//       defined   -> write-first: a read and write to the same address in one
//                    cycle returns the new dadoEscr on dadoLido
//       undefined -> read-first: the same case returns the old contents
//    In both builds the memory holds dadoEscr after that edge.
//
//    Ports:
//       clock       in   rising-edge clock
//       reset       in   synchronous active-high reset, dominates requests
//       memWrite    in   write request
//       memLoad     in   read request
//       endereco    in   word address
//       dadoEscr    in   write data
//       dadoLido    out  read data, holds between reads, 0 for rejected reads
//       lidoValido  out  one-cycle pulse when dadoLido was updated
//       pronto      out  sweep finished, requests accepted
//       erroEnd     out  last request addressed endereco >= DEPTH
//
//    state    | meaning
//    ---------+------------------------------------------------------------
//    MEM_INIT | zero-fill sweep, one word per cycle; requests ignored
//    MEM_RUN  | normal service of memWrite / memLoad

module memoria_dados_param
   import memoria_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              memWrite,
   input  logic              memLoad,
   input  logic [ADDR_W-1:0] endereco,
   input  logic [DATA_W-1:0] dadoEscr,
   output logic [DATA_W-1:0] dadoLido,
   output logic              lidoValido,
   output logic              pronto,
   output logic              erroEnd
);

   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ULTIMO    = ADDR_W'(DEPTH - 1);

   memoria_estado_t   estado;
   logic [ADDR_W-1:0] cnt;

   logic              em_faixa;
   logic              em_run;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic              arr_re;
   logic [DATA_W-1:0] arr_rdata;

   // Last accepted read was out of range: dadoLido must show zero.
   logic              rd_fora;

`ifdef MEMORIA_BYPASS_EN
   // Last accepted read collided with a write to the same word; the array
   // returned the old contents, so the captured write data is shown instead.
   logic              rd_byp;
   logic [DATA_W-1:0] byp_dado;
`endif

   assign em_faixa = ({1'b0, endereco} < DEPTH_LIM);
   assign em_run   = (estado == MEM_RUN);

   // Write mux: the sweep owns the write port until the memory is ready.
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = endereco;
      arr_wdata = dadoEscr;
      if (!reset) begin
         if (estado == MEM_INIT) begin
            arr_we    = 1'b1;
            arr_waddr = cnt;
            arr_wdata = '0;
         end else begin
            arr_we    = memWrite & em_faixa;
         end
      end
   end

   assign arr_re = ~reset & em_run & memLoad & em_faixa;

   memoria_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clock (clock),
      .reset (reset),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (arr_re),
      .raddr (endereco),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado     <= MEM_INIT;
         cnt        <= '0;
         pronto     <= 1'b0;
         erroEnd    <= 1'b0;
         lidoValido <= 1'b0;
         rd_fora    <= 1'b0;
`ifdef MEMORIA_BYPASS_EN
         rd_byp     <= 1'b0;
         byp_dado   <= '0;
`endif
      end else begin
         unique case (estado)
            MEM_INIT: begin
               lidoValido <= 1'b0;
               if (cnt == ULTIMO) begin
                  estado <= MEM_RUN;
                  pronto <= 1'b1;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            MEM_RUN: begin
               lidoValido <= memLoad;
               if (memLoad) begin
                  rd_fora  <= ~em_faixa;
`ifdef MEMORIA_BYPASS_EN
                  rd_byp   <= memWrite & em_faixa;
                  byp_dado <= dadoEscr;
`endif
               end
               // Any request, accepted or rejected, reports on its address.
               if (memWrite || memLoad) begin
                  erroEnd <= ~em_faixa;
               end
            end
            default: begin
               estado <= MEM_INIT;
               cnt    <= '0;
            end
         endcase
      end
   end

   // All selects and sources are flops, so dadoLido changes only at the edge.
`ifdef MEMORIA_BYPASS_EN
   assign dadoLido = rd_fora ? '0 : (rd_byp ? byp_dado : arr_rdata);
`else
   assign dadoLido = rd_fora ? '0 : arr_rdata;
`endif

endmodule

// File: tb/tb_memoria_dados_param.sv
// Testbench for memoria_dados_param. Main instance (8-bit, 256-address,
// 16-word) is driven by directed then random stimulus; a reference model
// predicts each edge and pushes expected reads into a scoreboard that a
// negedge monitor drains. A second 16-bit/1024-word instance checks sweep
// length and a top-address round trip.

module tb_memoria_dados_param;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int DP = 16;

   localparam int DW2 = 16;
   localparam int AW2 = 10;
   localparam int DP2 = 1024;

`ifdef MEMORIA_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic          reset = 1'b1, memWrite = 1'b0, memLoad = 1'b0;
   logic [AW-1:0] endereco = '0;
   logic [DW-1:0] dadoEscr = '0;
   logic [DW-1:0] dadoLido;
   logic          lidoValido, pronto, erroEnd;

   memoria_dados_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clock(clk), .reset(reset), .memWrite(memWrite), .memLoad(memLoad),
      .endereco(endereco), .dadoEscr(dadoEscr), .dadoLido(dadoLido),
      .lidoValido(lidoValido), .pronto(pronto), .erroEnd(erroEnd)
   );

   logic           reset_b = 1'b1, wr_b = 1'b0, ld_b = 1'b0;
   logic [AW2-1:0] end_b = '0;
   logic [DW2-1:0] di_b = '0;
   logic [DW2-1:0] do_b;
   logic           val_b, pronto_b, err_b;
   bit             done_b = 1'b0;

   memoria_dados_param #(.DATA_W(DW2), .ADDR_W(AW2), .DEPTH(DP2)) dut_b (
      .clock(clk), .reset(reset_b), .memWrite(wr_b), .memLoad(ld_b),
      .endereco(end_b), .dadoEscr(di_b), .dadoLido(do_b),
      .lidoValido(val_b), .pronto(pronto_b), .erroEnd(err_b)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, exp, cyc);
      end
   endtask

   // Reference model: state after the most recently predicted edge.
   typedef struct {
      int            cyc;
      logic [DW-1:0] dado;
   } rd_t;
   rd_t sb[$];

   logic [DW-1:0] m_mem [DP];
   int            m_init_left = 0;
   bit            m_err = 1'b0;
   logic [DW-1:0] m_dout = '0;
   bit            n_valid = 1'b0;

   // Model view of the edge that has already happened, read by the monitor.
   bit            c_valid = 1'b0;
   bit            c_pronto = 1'b0;
   bit            c_err = 1'b0;
   logic [DW-1:0] c_dout = '0;

   task automatic predict(input bit r, input bit w, input bit l, input int a, input logic [DW-1:0] d);
      bit            inr;
      logic [DW-1:0] v;
      if (r) begin
         m_init_left = DP;
         m_err       = 1'b0;
         m_dout      = '0;
         for (int i = 0; i < DP; i++) m_mem[i] = '0;
         n_valid     = 1'b1;
      end else if (!n_valid) begin
         // nothing known before the first reset
      end else if (m_init_left > 0) begin
         m_init_left--;
      end else begin
         inr = (a < DP);
         if (l) begin
            if (!inr)             v = '0;
            else if (w && BYPASS) v = d;
            else                  v = m_mem[a];
            sb.push_back('{cyc + 1, v});
            m_dout = v;
         end
         if (w && inr) m_mem[a] = d;
         if (w || l)   m_err = !inr;
      end
   endtask

   task automatic step(input bit r, input bit w, input bit l, input int a, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      c_valid  = n_valid;
      c_pronto = (m_init_left == 0);
      c_err    = m_err;
      c_dout   = m_dout;
      reset    = r;
      memWrite = w;
      memLoad  = l;
      endereco = AW'(a);
      dadoEscr = d;
      predict(r, w, l, a, d);
   endtask

   // Monitor: compares the main instance against the model every cycle.
   bit  mon_ev;
   rd_t mon_e;
   always @(negedge clk) begin
      if (c_valid) begin
         mon_ev = (sb.size() > 0) && (sb[0].cyc == cyc);
         check("lidoValido", lidoValido, mon_ev);
         if (mon_ev) begin
            mon_e = sb.pop_front();
            check("dadoLido_read", dadoLido, mon_e.dado);
         end else begin
            check("dadoLido_hold", dadoLido, c_dout);
         end
         check("pronto", pronto, c_pronto);
         check("erroEnd", erroEnd, c_err);
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_asserts++;
            n_fail++;
            $display("FAIL read_missing: expected read at cycle %0d not seen by cycle %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
      end
   end

   // Wide/deep instance: sweep length and top-address round trip.
   initial begin
      int n;
      @(posedge clk);
      #1;
      reset_b = 1'b0;
      n = 0;
      while (!pronto_b && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b_sweep_cycles", n, DP2);
      check("b_no_valid_at_ready", val_b, 1'b0);
      wr_b  = 1'b1;
      end_b = AW2'(DP2 - 1);
      di_b  = 16'hBEEF;
      @(posedge clk);
      #1;
      wr_b = 1'b0;
      ld_b = 1'b1;
      @(posedge clk);
      #1;
      ld_b  = 1'b1;
      end_b = '0;
      check("b_top_valid", val_b, 1'b1);
      check("b_top_data", do_b, 16'hBEEF);
      @(posedge clk);
      #1;
      ld_b = 1'b0;
      check("b_zero_data", do_b, 16'h0000);
      check("b_erro", err_b, 1'b0);
      @(posedge clk);
      #1;
      check("b_idle_valid", val_b, 1'b0);
      check("b_idle_hold", do_b, 16'h0000);
      done_b = 1'b1;
   end

   initial begin
      bit r, w, l;
      // Reset, then read addr 3 every cycle through the whole sweep.
      step(1, 0, 0, 0, 0);
      repeat (20) step(0, 0, 1, 3, 0);

      // Reset again, interrupt the sweep after 7 cycles, restart.
      step(1, 0, 0, 0, 0);
      repeat (7) step(0, 0, 1, 3, 0);
      step(1, 0, 0, 0, 0);
      repeat (17) step(0, 0, 0, 0, 0);

      // Basic write / read / hold.
      step(0, 1, 0, 5, 8'hA5);
      step(0, 0, 1, 5, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Out-of-range write and read, then in-range read clears the flag.
      step(0, 1, 0, 20, 8'h3C);
      step(0, 0, 1, 20, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 4, 0);
      step(0, 0, 0, 0, 0);

      // Same-cycle read and write to one address.
      step(0, 1, 0, 9, 8'h11);
      step(0, 1, 1, 9, 8'h77);
      step(0, 0, 1, 9, 0);
      step(0, 0, 0, 0, 0);

      // Random traffic including rare resets and out-of-range addresses.
      for (int k = 0; k < 600; k++) begin
         r = ($urandom_range(0, 99) == 0);
         w = $urandom_range(0, 1) == 1;
         l = $urandom_range(0, 1) == 1;
         step(r, w, l, $urandom_range(0, 23), DW'($urandom));
      end

      // Fill with non-zero data, reset, and confirm the sweep cleared it all.
      repeat (17) step(0, 0, 0, 0, 0);
      for (int a = 0; a < DP; a++) step(0, 1, 0, a, DW'(a * 13 + 1));
      step(1, 0, 0, 0, 0);
      repeat (17) step(0, 0, 0, 0, 0);
      for (int a = 0; a < DP; a++) step(0, 0, 1, a, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      check("scoreboard_drained", sb.size(), 0);

      for (int i = 0; i < 5000 && !done_b; i++) @(posedge clk);
      check("b_finished", done_b, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
